// File: rtl/bmp_pkg.sv
// Shared BMP definitions: the pixel-packer FSM state type, row geometry
// helpers and the RGB888 -> RGB565 conversion used by the BMP copier path.
package bmp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GATHER,
    WRITE,
    PAD,
    DONE
  } bmp_pack_state_t;

  // Bytes occupied by one 24bpp row before padding.
  function automatic int row_bytes(input int width);
    return 3 * width;
  endfunction

  // Padding bytes that round a 24bpp row up to a 4-byte boundary (0..3).
  function automatic int pad_bytes(input int width);
    return (4 - (row_bytes(width) % 4)) % 4;
  endfunction

  // Keep the most significant bits of each channel.
  function automatic logic [15:0] rgb888_to_565(input logic [7:0] r,
                                                input logic [7:0] g,
                                                input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

endpackage

// File: rtl/bmp_pixel_packer.sv
// bmp_pixel_packer: turns the 24bpp BGR pixel-array byte stream of a BMP file
// into one RGB565 SDRAM word write per pixel, dropping the row padding.
// Optional feature macro: BMP_BOTTOM_UP_EN (file row 0 lands on the bottom
// display row; row_base walks downwards in memory).
module bmp_pixel_packer
  import bmp_pkg::*;
#(
  parameter int          IMG_WIDTH  = 800,
  parameter int          IMG_HEIGHT = 600,
  parameter logic [23:0] BASE_ADDR  = 24'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        m_valid_write,
  input  logic        m_ready_write,
  output logic [23:0] m_addr_write,
  output logic [15:0] m_in_data,
  output logic        Serial_access_write,
  output logic        busy,
  output logic        done
);

  localparam int PAD_LEN = pad_bytes(IMG_WIDTH);
  localparam int COL_W   = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [1:0]       PAD_LAST = 2'(PAD_LEN - 1);
  localparam logic [23:0]      ROW_STEP = 24'(IMG_WIDTH);

`ifdef BMP_BOTTOM_UP_EN
  localparam logic [23:0] ROW_BASE_INIT = BASE_ADDR + 24'((IMG_HEIGHT - 1) * IMG_WIDTH);
`else
  localparam logic [23:0] ROW_BASE_INIT = BASE_ADDR;
`endif

  bmp_pack_state_t  r_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [1:0]       r_byte_idx;
  logic [1:0]       r_pad_cnt;
  logic [7:0]       r_b;
  logic [7:0]       r_g;
  logic [23:0]      r_row_base;
  logic             r_byte_ready;
  logic             r_m_valid;
  logic [23:0]      r_m_addr;
  logic [15:0]      r_m_data;
  logic             r_serial;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_last_col;
  logic             w_last_row;
  logic             w_row_end;
  logic [23:0]      w_next_row_base;

  assign w_accept   = byte_valid & r_byte_ready;
  assign w_last_col = (r_col == COL_LAST);
  assign w_last_row = (r_row == ROW_LAST);

`ifdef BMP_BOTTOM_UP_EN
  assign w_next_row_base = r_row_base - ROW_STEP;
`else
  assign w_next_row_base = r_row_base + ROW_STEP;
`endif

  // Row end fires on the last pixel's handshake (no padding) or on the last pad byte.
  assign w_row_end = ((r_state == WRITE) && m_ready_write && w_last_col && (PAD_LEN == 0)) ||
                     ((r_state == PAD) && w_accept && (r_pad_cnt == PAD_LAST));

  // Frame FSM with registered handshake outputs and the address/pixel datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_byte_idx   <= '0;
      r_pad_cnt    <= '0;
      r_b          <= '0;
      r_g          <= '0;
      r_row_base   <= '0;
      r_byte_ready <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_addr     <= '0;
      r_m_data     <= '0;
      r_serial     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // reads the pre-edge values; the row-end block below overrides the case.
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state      <= GATHER;
            r_col        <= '0;
            r_row        <= '0;
            r_byte_idx   <= '0;
            r_row_base   <= ROW_BASE_INIT;
            r_byte_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
          end
        end
        GATHER: begin
          if (w_accept) begin
            case (r_byte_idx)
              2'd0: begin
                r_b        <= byte_in;
                r_byte_idx <= 2'd1;
              end
              2'd1: begin
                r_g        <= byte_in;
                r_byte_idx <= 2'd2;
              end
              default: begin
                r_m_data     <= rgb888_to_565(byte_in, r_g, r_b);
                r_m_addr     <= r_row_base + 24'(r_col);
                r_serial     <= ~w_last_col;
                r_m_valid    <= 1'b1;
                r_byte_ready <= 1'b0;
                r_byte_idx   <= 2'd0;
                r_state      <= WRITE;
              end
            endcase
          end
        end
        WRITE: begin
          if (m_ready_write) begin
            r_m_valid <= 1'b0;
            if (!w_last_col) begin
              r_col        <= r_col + 1'b1;
              r_byte_ready <= 1'b1;
              r_state      <= GATHER;
            end else if (PAD_LEN != 0) begin
              r_pad_cnt    <= '0;
              r_byte_ready <= 1'b1;
              r_state      <= PAD;
            end
          end
        end
        PAD: begin
          if (w_accept) begin
            r_pad_cnt <= r_pad_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_row_end) begin
        r_col <= '0;
        if (w_last_row) begin
          r_state      <= DONE;
          r_byte_ready <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b1;
        end else begin
          r_row        <= r_row + 1'b1;
          r_row_base   <= w_next_row_base;
          r_byte_ready <= 1'b1;
          r_state      <= GATHER;
        end
      end
    end
  end

  assign byte_ready          = r_byte_ready;
  assign m_valid_write       = r_m_valid;
  assign m_addr_write        = r_m_addr;
  assign m_in_data           = r_m_data;
  assign Serial_access_write = r_serial;
  assign busy                = r_busy;
  assign done                = r_done;

endmodule

// File: tb/tb_bmp_pixel_packer.sv
// Self-checking bench for bmp_pixel_packer: three instances (4x2 no padding,
// 3x2 with 3 pad bytes, 1x3 with 1 pad byte) driven one at a time, with a
// scoreboard queue of expected SDRAM writes built from the bench's own model.
module tb_bmp_pixel_packer;

`ifdef BMP_BOTTOM_UP_EN
  localparam bit BOTTOM_UP = 1'b1;
`else
  localparam bit BOTTOM_UP = 1'b0;
`endif

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
    logic        ser;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic byte_valid;
  logic m_ready;
  logic [7:0] byte_in;
  int sel;

  logic [2:0]        br, mv, sa, bz, dn;
  logic [2:0][23:0]  ad;
  logic [2:0][15:0]  dt;

  logic        cur_br, cur_mv, cur_sa, cur_bz, cur_dn;
  logic [23:0] cur_ad;
  logic [15:0] cur_dt;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    cur_br = br[sel];
    cur_mv = mv[sel];
    cur_sa = sa[sel];
    cur_bz = bz[sel];
    cur_dn = dn[sel];
    cur_ad = ad[sel];
    cur_dt = dt[sel];
  end

  bmp_pixel_packer #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .BASE_ADDR(24'd0)) dut_a (
    .clk(clk), .rst(rst), .start(start && sel == 0), .byte_in(byte_in),
    .byte_valid(byte_valid && sel == 0), .byte_ready(br[0]),
    .m_valid_write(mv[0]), .m_ready_write(m_ready && sel == 0),
    .m_addr_write(ad[0]), .m_in_data(dt[0]), .Serial_access_write(sa[0]),
    .busy(bz[0]), .done(dn[0]));

  bmp_pixel_packer #(.IMG_WIDTH(3), .IMG_HEIGHT(2), .BASE_ADDR(24'd100)) dut_b (
    .clk(clk), .rst(rst), .start(start && sel == 1), .byte_in(byte_in),
    .byte_valid(byte_valid && sel == 1), .byte_ready(br[1]),
    .m_valid_write(mv[1]), .m_ready_write(m_ready && sel == 1),
    .m_addr_write(ad[1]), .m_in_data(dt[1]), .Serial_access_write(sa[1]),
    .busy(bz[1]), .done(dn[1]));

  bmp_pixel_packer #(.IMG_WIDTH(1), .IMG_HEIGHT(3), .BASE_ADDR(24'd7)) dut_c (
    .clk(clk), .rst(rst), .start(start && sel == 2), .byte_in(byte_in),
    .byte_valid(byte_valid && sel == 2), .byte_ready(br[2]),
    .m_valid_write(mv[2]), .m_ready_write(m_ready && sel == 2),
    .m_addr_write(ad[2]), .m_in_data(dt[2]), .Serial_access_write(sa[2]),
    .busy(bz[2]), .done(dn[2]));

  function automatic int wid(input int s);
    return (s == 0) ? 4 : (s == 1) ? 3 : 1;
  endfunction

  function automatic int hgt(input int s);
    return (s == 2) ? 3 : 2;
  endfunction

  function automatic int base(input int s);
    return (s == 0) ? 0 : (s == 1) ? 100 : 7;
  endfunction

  // Present one byte from a negedge, wait (bounded) for byte_ready, let one posedge accept it.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (cur_br !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cur_br !== 1'b1) begin
      errors++;
      $display("FAIL byte_ready_timeout: byte_ready=%b after %0d cycles, required 1", cur_br, n);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // Drive a whole frame into instance s; optionally stall one write and pulse start mid-frame.
  task automatic run_frame(input int s, input int stall_px, input int stall_len,
                           input bit pulse_mid_start);
    int w, h, pad, idx, writes, drow;
    logic [7:0] pb, pg, pr;
    exp_t e;
    sel = s;
    w = wid(s);
    h = hgt(s);
    pad = (4 - (3 * w) % 4) % 4;
    idx = 0;
    writes = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (cur_bz !== 1'b1 || cur_dn !== 1'b0 || cur_br !== 1'b1) begin
      errors++;
      $display("FAIL start_state: busy=%b done=%b byte_ready=%b, required 1 0 1", cur_bz, cur_dn, cur_br);
    end
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (idx == 0) begin
          pb = 8'h10; pg = 8'h20; pr = 8'hF8;
        end else begin
          pb = 8'($urandom); pg = 8'($urandom); pr = 8'($urandom);
        end
        if (idx == 2) begin
          byte_valid = 1'b0;
          repeat (2) @(negedge clk);
        end
        send_byte(pb);
        send_byte(pg);
        checks++;
        if (cur_mv !== 1'b0) begin
          errors++;
          $display("FAIL early_valid: m_valid_write=%b before R byte, required 0", cur_mv);
        end
        if (pulse_mid_start && idx == 1) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
        send_byte(pr);
        drow = BOTTOM_UP ? (h - 1 - r) : r;
        sb.push_back('{addr: 24'(base(s) + drow * w + c),
                       data: {pr[7:3], pg[7:2], pb[7:3]},
                       ser:  (c != w - 1)});
        checks++;
        if (cur_mv !== 1'b1) begin
          errors++;
          $display("FAIL write_latency: m_valid_write=%b one cycle after R byte, required 1", cur_mv);
        end
        e = sb.pop_front();
        checks++;
        if (cur_ad !== e.addr || cur_dt !== e.data || cur_sa !== e.ser) begin
          errors++;
          $display("FAIL write_content px%0d: addr=%0d data=%h serial=%b, required addr=%0d data=%h serial=%b",
                   idx, cur_ad, cur_dt, cur_sa, e.addr, e.data, e.ser);
        end
        if (idx == 0) begin
          checks++;
          if (cur_dt !== 16'hF902) begin
            errors++;
            $display("FAIL pixel_pack: data=%h, required f902", cur_dt);
          end
        end
        if (idx == stall_px) begin
          for (int k = 0; k < stall_len; k++) begin
            start = pulse_mid_start && (k == 0);
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (cur_mv !== 1'b1 || cur_ad !== e.addr || cur_dt !== e.data || cur_br !== 1'b0) begin
              errors++;
              $display("FAIL stall_hold cyc%0d: valid=%b addr=%0d data=%h byte_ready=%b, required 1 %0d %h 0",
                       k, cur_mv, cur_ad, cur_dt, cur_br, e.addr, e.data);
            end
          end
        end
        m_ready = 1'b1;
        if (cur_mv === 1'b1) writes++;
        @(negedge clk);
        m_ready = 1'b0;
        checks++;
        if (cur_mv !== 1'b0) begin
          errors++;
          $display("FAIL valid_drop: m_valid_write=%b after handshake, required 0", cur_mv);
        end
        idx++;
      end
      for (int p = 0; p < pad; p++) begin
        checks++;
        if (cur_br !== 1'b1) begin
          errors++;
          $display("FAIL pad_ready row%0d byte%0d: byte_ready=%b, required 1", r, p, cur_br);
        end
        send_byte(8'hAA);
        checks++;
        if (cur_mv !== 1'b0) begin
          errors++;
          $display("FAIL pad_write row%0d byte%0d: m_valid_write=%b, required 0", r, p, cur_mv);
        end
      end
    end
    checks++;
    if (cur_dn !== 1'b1 || cur_bz !== 1'b0 || cur_br !== 1'b0) begin
      errors++;
      $display("FAIL frame_done: done=%b busy=%b byte_ready=%b, required 1 0 0", cur_dn, cur_bz, cur_br);
    end
    checks++;
    if (writes != w * h || sb.size() != 0) begin
      errors++;
      $display("FAIL write_count: writes=%0d left=%0d, required %0d and 0", writes, sb.size(), w * h);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      checks++;
      if ({cur_br, cur_mv, cur_sa, cur_bz, cur_dn} !== 5'b0 || cur_ad !== 24'd0 || cur_dt !== 16'd0) begin
        errors++;
        $display("FAIL reset_state dut%0d: ready=%b valid=%b serial=%b busy=%b done=%b addr=%0d data=%h, required all 0",
                 s, cur_br, cur_mv, cur_sa, cur_bz, cur_dn, cur_ad, cur_dt);
      end
    end
  endtask

  task automatic test_basic_frame();
    run_frame(0, -1, 0, 1'b0);
  endtask

  task automatic test_padding();
    run_frame(1, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_frame(0, 2, 10, 1'b1);
  endtask

  task automatic test_width_one();
    run_frame(2, 1, 3, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    sel = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    send_byte(8'h04);
    send_byte(8'h05);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({cur_br, cur_mv, cur_sa, cur_bz, cur_dn} !== 5'b0 || cur_ad !== 24'd0 || cur_dt !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: ready=%b valid=%b serial=%b busy=%b done=%b addr=%0d data=%h, required all 0",
               cur_br, cur_mv, cur_sa, cur_bz, cur_dn, cur_ad, cur_dt);
    end
    run_frame(0, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame(1, 0, 2, 1'b1);
    run_frame(1, -1, 0, 1'b0);
  endtask

  initial begin
    sel = 0;
    rst = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    m_ready = 1'b0;
    byte_in = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_padding();
    test_backpressure();
    test_width_one();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
